// File: rtl/hw_barrier_pkg.sv
`default_nettype none
// ============================================================================
// hw_barrier_pkg : register map, id-width helper and per-barrier state record
// Revision 1.0
// ============================================================================
package hw_barrier_pkg;

    // Field widths of slot_state_t; the top-level NB_CORES/GEN_W defaults follow these
    localparam int unsigned SLOT_NB_CORES = 4;
    localparam int unsigned SLOT_GEN_W    = 8;

    localparam logic [2:0] REG_TRIG_MASK   = 3'd0;
    localparam logic [2:0] REG_STATUS      = 3'd1;
    localparam logic [2:0] REG_GEN         = 3'd2;
    localparam logic [2:0] REG_TARGET_MASK = 3'd3;
    localparam logic [2:0] REG_TRIGGER     = 3'd4;
    localparam logic [2:0] REG_ERROR       = 3'd5;

    function automatic int unsigned bid_width(input int unsigned nb_barriers);
        return (nb_barriers < 2) ? 1 : $clog2(nb_barriers);
    endfunction

    typedef struct packed {
        logic [SLOT_NB_CORES-1:0] trig_mask;
        logic [SLOT_NB_CORES-1:0] target_mask;
        logic [SLOT_NB_CORES-1:0] status;
        logic [SLOT_NB_CORES-1:0] error;
        logic [SLOT_GEN_W-1:0]    gen;
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/hw_barrier_slot.sv
`default_nettype none
// ============================================================================
// hw_barrier_slot : one barrier - masks, arrival status, error flags, generation
// Revision 1.0
// ============================================================================
module hw_barrier_slot
    import hw_barrier_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [SLOT_NB_CORES-1:0] arrive_i,
    input  logic                     trig_mask_we_i,
    input  logic                     target_mask_we_i,
    input  logic [SLOT_NB_CORES-1:0] error_clr_i,
    input  logic [SLOT_NB_CORES-1:0] wdata_i,
    output slot_state_t              state_o,
    output logic                     fire_o,
    output logic                     matched_o
);

    slot_state_t state_q;
    slot_state_t state_d;
    logic        matched_q;
    logic        matched_d;
    logic        match;

    assign match = (state_q.trig_mask != '0) &&
                   ((state_q.status & state_q.trig_mask) == state_q.trig_mask);

    always_comb begin
        state_d       = state_q;
        matched_d     = 1'b0;
        state_d.error = state_q.error & ~error_clr_i;
        if (trig_mask_we_i) begin
            state_d.trig_mask = wdata_i;
            state_d.status    = '0;
        end else if (match) begin
            // Arrivals in the match cycle open the next generation unchecked
            state_d.status = arrive_i;
            state_d.gen    = state_q.gen + SLOT_GEN_W'(1);
            matched_d      = 1'b1;
        end else begin
            state_d.error  = state_d.error | (arrive_i & state_q.status);
            state_d.status = state_q.status | arrive_i;
        end
        if (target_mask_we_i) begin
            state_d.target_mask = wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= '0;
            matched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            matched_q <= matched_d;
        end
    end

    assign state_o   = state_q;
    assign fire_o    = matched_d;
    assign matched_o = matched_q;

endmodule
`default_nettype wire

// File: rtl/hw_barrier_array.sv
`default_nettype none
// ============================================================================
// hw_barrier_array : NB_BARRIERS hardware barriers with bus access and events
// Revision 1.0
// ============================================================================
module hw_barrier_array
    import hw_barrier_pkg::*;
#(
    parameter int unsigned NB_CORES    = SLOT_NB_CORES,
    parameter int unsigned NB_BARRIERS = 8,
    parameter int unsigned GEN_W       = SLOT_GEN_W
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NB_CORES-1:0]                        trig_valid_i,
    input  logic [NB_CORES*bid_width(NB_BARRIERS)-1:0] trig_bid_i,
    input  logic                                       req_i,
    input  logic                                       wen_i,
    input  logic [31:0]                                add_i,
    input  logic [31:0]                                wdata_i,
    output logic                                       gnt_o,
    output logic                                       r_valid_o,
    output logic [31:0]                                r_rdata_o,
    output logic [NB_BARRIERS*NB_CORES-1:0]            barrier_status_o,
    output logic [NB_CORES-1:0]                        barrier_events_o,
    output logic [NB_BARRIERS-1:0]                     barrier_matched_o
);

    localparam int unsigned BID_W = bid_width(NB_BARRIERS);

    logic [BID_W-1:0]       bus_bid;
    logic [2:0]             bus_reg;
    logic                   bus_wr;
    logic                   bus_rd;

    logic [NB_CORES-1:0]    arrive  [NB_BARRIERS];
    logic [NB_CORES-1:0]    err_clr [NB_BARRIERS];
    logic [NB_BARRIERS-1:0] trig_we;
    logic [NB_BARRIERS-1:0] tgt_we;
    logic [NB_BARRIERS-1:0] fire;
    slot_state_t            state   [NB_BARRIERS];

    logic                   r_valid_q, r_valid_d;
    logic [31:0]            r_rdata_q, r_rdata_d;
    logic [NB_CORES-1:0]    events_q, events_d;

    logic                   unused_bits;

    assign bus_bid     = add_i[5 +: BID_W];
    assign bus_reg     = add_i[4:2];
    assign bus_wr      = req_i & ~wen_i;
    assign bus_rd      = req_i & wen_i;
    assign gnt_o       = req_i;
    assign unused_bits = ^{add_i[31:5+BID_W], add_i[1:0], wdata_i[31:NB_CORES]};

    always_comb begin
        for (int b = 0; b < NB_BARRIERS; b++) begin
            arrive[b]  = '0;
            err_clr[b] = '0;
            trig_we[b] = 1'b0;
            tgt_we[b]  = 1'b0;
            for (int c = 0; c < NB_CORES; c++) begin
                if (trig_valid_i[c] && (trig_bid_i[c*BID_W +: BID_W] == BID_W'(b))) begin
                    arrive[b][c] = 1'b1;
                end
            end
            if (bus_wr && (bus_bid == BID_W'(b))) begin
                case (bus_reg)
                    REG_TRIG_MASK:   trig_we[b] = 1'b1;
                    REG_TARGET_MASK: tgt_we[b]  = 1'b1;
                    REG_TRIGGER:     arrive[b]  = arrive[b] | wdata_i[NB_CORES-1:0];
                    REG_ERROR:       err_clr[b] = wdata_i[NB_CORES-1:0];
                    default:         ;
                endcase
            end
        end
    end

    for (genvar b = 0; b < NB_BARRIERS; b++) begin : g_slot
        hw_barrier_slot u_slot (
            .clk_i            (clk_i),
            .rst_i            (rst_i),
            .arrive_i         (arrive[b]),
            .trig_mask_we_i   (trig_we[b]),
            .target_mask_we_i (tgt_we[b]),
            .error_clr_i      (err_clr[b]),
            .wdata_i          (wdata_i[NB_CORES-1:0]),
            .state_o          (state[b]),
            .fire_o           (fire[b]),
            .matched_o        (barrier_matched_o[b])
        );
        assign barrier_status_o[b*NB_CORES +: NB_CORES] = state[b].status;
    end

    // Read data is the register value before this cycle's update lands
    always_comb begin
        r_valid_d = req_i;
        r_rdata_d = '0;
        if (bus_rd) begin
            case (bus_reg)
                REG_TRIG_MASK:   r_rdata_d[NB_CORES-1:0] = state[bus_bid].trig_mask;
                REG_STATUS:      r_rdata_d[NB_CORES-1:0] = state[bus_bid].status;
                REG_GEN:         r_rdata_d[GEN_W-1:0]    = state[bus_bid].gen;
                REG_TARGET_MASK: r_rdata_d[NB_CORES-1:0] = state[bus_bid].target_mask;
                REG_ERROR:       r_rdata_d[NB_CORES-1:0] = state[bus_bid].error;
                default:         r_rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        events_d = '0;
        for (int b = 0; b < NB_BARRIERS; b++) begin
            if (fire[b]) begin
                events_d = events_d | state[b].target_mask;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            events_q  <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_rdata_q <= r_rdata_d;
            events_q  <= events_d;
        end
    end

    assign r_valid_o        = r_valid_q;
    assign r_rdata_o        = r_rdata_q;
    assign barrier_events_o = events_q;

endmodule
`default_nettype wire
